// File: rtl/vr_rr_arbiter.sv
// N-to-1 round-robin valid/ready merger with one registered output stage and source-index tagging.
// Optional packet locking (up_last_in/dn_last_out) is enabled by defining VR_RR_ARB_LAST_LOCK_EN.
module vr_rr_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 32,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       up_valid_in,
    input  logic [N_REQ*WIDTH-1:0] up_data_in,
    output logic [N_REQ-1:0]       up_ready_out,
    output logic                   dn_valid_out,
    output logic [WIDTH-1:0]       dn_data_out,
    output logic [IDW-1:0]         dn_id_out,
    input  logic                   dn_ready_in
`ifdef VR_RR_ARB_LAST_LOCK_EN
    ,
    input  logic [N_REQ-1:0]       up_last_in,
    output logic                   dn_last_out
`endif
);

    // Handshake: a beat moves when valid and ready are both high at posedge clk;
    // a source holds valid and data stable until that happens.
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_ptr;

    logic             w_load;
    logic             w_found;
    logic             w_fire;
    logic             w_adv;
    logic [IDW-1:0]   w_grant_idx;
    logic [IDW-1:0]   w_next_ptr;
    logic [N_REQ-1:0] w_eligible;

`ifdef VR_RR_ARB_LAST_LOCK_EN
    logic             r_last;
    logic             r_lock;
    logic [IDW-1:0]   r_lock_id;

    // While a packet is open only its owner may be granted, even if it is idle.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_eligible[i] = up_valid_in[i] & (!r_lock | (r_lock_id == IDW'(i)));
        end
    end

    assign w_adv       = up_last_in[w_grant_idx];
    assign dn_last_out = r_last;
`else
    assign w_eligible = up_valid_in;
    assign w_adv      = 1'b1;
`endif

    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_eligible[IDW'((int'(r_ptr) + k) % N_REQ)]) begin
                w_found     = 1'b1;
                w_grant_idx = IDW'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    assign w_load       = !r_valid | dn_ready_in;
    assign w_fire       = w_load & w_found & !rst;
    assign up_ready_out = w_fire ? (N_REQ'(1) << w_grant_idx) : '0;
    assign w_next_ptr   = (w_grant_idx == IDW'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
`ifdef VR_RR_ARB_LAST_LOCK_EN
            r_last    <= 1'b0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
`endif
        end else if (w_load) begin
            r_valid <= w_found;
            if (w_found) begin
                r_data <= up_data_in[w_grant_idx*WIDTH +: WIDTH];
                r_id   <= w_grant_idx;
                // The pointer only moves when a packet closes, so a locked owner keeps priority.
                if (w_adv) begin
                    r_ptr <= w_next_ptr;
                end
`ifdef VR_RR_ARB_LAST_LOCK_EN
                r_last    <= up_last_in[w_grant_idx];
                r_lock    <= !up_last_in[w_grant_idx];
                r_lock_id <= w_grant_idx;
`endif
            end
        end
    end

    assign dn_valid_out = r_valid;
    assign dn_data_out  = r_data;
    assign dn_id_out    = r_id;

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Self-checking bench for vr_rr_arbiter: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the round-robin/lock rules.
module tb_vr_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;
    localparam int SBW = IDW + W;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   up_valid_in;
    logic [N*W-1:0] up_data_in;
    logic [N-1:0]   up_ready_out;
    logic           dn_valid_out;
    logic [W-1:0]   dn_data_out;
    logic [IDW-1:0] dn_id_out;
    logic           dn_ready_in;
    logic [N-1:0]   up_last_in;
`ifdef VR_RR_ARB_LAST_LOCK_EN
    logic           dn_last_out;
`endif

    always #5 clk = ~clk;

    vr_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .up_valid_in  (up_valid_in),
        .up_data_in   (up_data_in),
        .up_ready_out (up_ready_out),
        .dn_valid_out (dn_valid_out),
        .dn_data_out  (dn_data_out),
        .dn_id_out    (dn_id_out),
        .dn_ready_in  (dn_ready_in)
`ifdef VR_RR_ARB_LAST_LOCK_EN
        ,
        .up_last_in   (up_last_in),
        .dn_last_out  (dn_last_out)
`endif
    );

    // Reference model state
    bit             m_valid;
    logic [W-1:0]   m_data;
    int             m_id;
    bit             m_last;
    int             m_ptr;
    bit             m_lock;
    int             m_lock_id;
    logic [SBW-1:0] exp_q[$];

    int n_checks;
    int n_errors;
    bit last_fire;
    int last_g;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_id      = 0;
        m_last    = 1'b0;
        m_ptr     = 0;
        m_lock    = 1'b0;
        m_lock_id = 0;
        exp_q.delete();
    endtask

    // One clock: check combinational ready, advance the model on the edge, check registered outputs.
    task automatic step();
        bit             found;
        bit             load;
        bit             lst;
        int             g;
        logic [N-1:0]   exp_rdy;
        logic [SBW-1:0] beat;
        #1;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!found && up_valid_in[i] && (!m_lock || i == m_lock_id)) begin
                found = 1'b1;
                g     = i;
            end
        end
        load    = !m_valid || dn_ready_in;
        exp_rdy = (load && found && !rst) ? (N'(1) << g) : '0;
        check("up_ready", up_ready_out, exp_rdy);
        if (!rst && m_valid && dn_ready_in && exp_q.size() > 0) begin
            beat = exp_q.pop_front();
            check("sb_beat", {dn_id_out, dn_data_out}, beat);
        end
        last_fire = load && found && !rst;
        last_g    = g;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (load) begin
            if (found) begin
`ifdef VR_RR_ARB_LAST_LOCK_EN
                lst       = up_last_in[g];
                m_last    = lst;
                m_lock    = !lst;
                m_lock_id = g;
`else
                lst = 1'b1;
`endif
                m_valid = 1'b1;
                m_data  = up_data_in[g*W +: W];
                m_id    = g;
                exp_q.push_back({IDW'(g), m_data});
                if (lst) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("dn_valid", dn_valid_out, m_valid);
        check("dn_data", dn_data_out, m_data);
        check("dn_id", dn_id_out, m_id);
`ifdef VR_RR_ARB_LAST_LOCK_EN
        check("dn_last", dn_last_out, m_last);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst         = 1'b1;
        up_valid_in = '1;
        up_last_in  = '1;
        dn_ready_in = 1'b1;
        for (int i = 0; i < N; i++) up_data_in[i*W +: W] = 32'hA0 + i;

        // Reset held two cycles with every requester asking
        step();
        step();
        check("rst_dn_valid", dn_valid_out, 0);
        check("rst_up_ready", up_ready_out, 0);
        check("rst_dn_id", dn_id_out, 0);
        rst = 1'b0;

        // Fairness: ids rotate 0..3 at one beat per cycle
        for (int k = 0; k < 8; k++) begin
            step();
            check("fair_valid", dn_valid_out, 1);
            check("fair_id", dn_id_out, k % 4);
            check("fair_data", dn_data_out, 32'hA0 + k % 4);
        end

        // Stall with id 2 / 0x55 on the output
        up_valid_in = 4'b0100;
        up_data_in[2*W +: W] = 32'h55;
        step();
        check("stall_load_id", dn_id_out, 2);
        dn_ready_in = 1'b0;
        up_valid_in = '1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_id", dn_id_out, 2);
            check("stall_data", dn_data_out, 32'h55);
            check("stall_rdy", up_ready_out, 0);
        end
        dn_ready_in = 1'b1;
        step();
        check("after_stall_id", dn_id_out, 3);

        // Sparse requests and wrap
        up_valid_in = '0;
        step();
        check("idle_valid", dn_valid_out, 0);
        up_valid_in = 4'b0010;
        step();
        check("sparse_id1", dn_id_out, 1);
        up_valid_in = 4'b0001;
        step();
        check("sparse_id0", dn_id_out, 0);
        up_valid_in = '0;
        step();
        check("sparse_idle", dn_valid_out, 0);
        check("sparse_hold_id", dn_id_out, 0);
        up_valid_in = 4'b0011;
        step();
        check("sparse_ptr1", dn_id_out, 1);

`ifdef VR_RR_ARB_LAST_LOCK_EN
        // Three-beat packet from req0 with a two-cycle gap while req1 waits
        up_valid_in = '0;
        step();
        up_valid_in = 4'b0011;
        up_last_in  = 4'b1110;
        up_data_in[0*W +: W] = 32'h10;
        step();
        check("lock_b1_id", dn_id_out, 0);
        check("lock_b1_last", dn_last_out, 0);
        up_data_in[0*W +: W] = 32'h11;
        step();
        check("lock_b2_id", dn_id_out, 0);
        up_valid_in = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            step();
            check("lock_gap_rdy", up_ready_out, 0);
            check("lock_gap_valid", dn_valid_out, 0);
        end
        up_valid_in = 4'b0011;
        up_last_in  = 4'b1111;
        up_data_in[0*W +: W] = 32'h12;
        step();
        check("lock_b3_id", dn_id_out, 0);
        check("lock_b3_data", dn_data_out, 32'h12);
        check("lock_b3_last", dn_last_out, 1);
        up_valid_in = 4'b0010;
        step();
        check("lock_next_id", dn_id_out, 1);
`endif

        // Reset while a beat is stalled (and, with locking, mid-packet)
        up_valid_in = 4'b0100;
        up_last_in  = 4'b1011;
        dn_ready_in = 1'b1;
        step();
        dn_ready_in = 1'b0;
        up_valid_in = '1;
        step();
        check("midrst_pending", dn_valid_out, 1);
        rst = 1'b1;
        step();
        check("midrst_drop", dn_valid_out, 0);
        rst         = 1'b0;
        dn_ready_in = 1'b1;
        up_last_in  = '1;
        step();
        check("midrst_ptr0", dn_id_out, 0);

        // Randomized traffic obeying the hold-until-fired rule
        for (int c = 0; c < 400; c++) begin
            if (last_fire) up_valid_in[last_g] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!up_valid_in[i] && $urandom_range(0, 2) != 0) begin
                    up_valid_in[i]       = 1'b1;
                    up_data_in[i*W +: W] = $urandom;
                    up_last_in[i]        = ($urandom_range(0, 2) != 0);
                end
            end
            dn_ready_in = ($urandom_range(0, 3) != 0);
            rst         = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
